// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Used by program_loader and byte_packer.
package loader_pkg;

  localparam int XLEN       = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_LEN0 = 3'd0,
    ST_LEN1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Collects four stream bytes, least-significant first, into one 32-bit word.
// word_valid/word are combinational and fire on the fourth accepted byte.
module byte_packer
  import loader_pkg::*;
(
  input  logic            clk,
  input  logic            areset,
  input  logic            clr,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            word_valid,
  output logic [XLEN-1:0] word
);

  logic [1:0]      lane_q;
  logic [XLEN-1:0] sr_q;

  // Bytes enter at the top and shift down, so the first byte ends in bits [7:0].
  always_ff @(posedge clk) begin
    if (areset || clr) begin
      lane_q <= 2'd0;
      sr_q   <= '0;
    end else if (byte_valid) begin
      lane_q <= lane_q + 2'd1;
      sr_q   <= {byte_data, sr_q[XLEN-1:8]};
    end
  end

  assign word_valid = byte_valid && (lane_q == 2'(WORD_BYTES - 1));
  assign word       = {byte_data, sr_q[XLEN-1:8]};

endmodule

// File: rtl/program_loader.sv
// Fills instruction memory from a byte stream, then releases the core from reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output loader_state_e     dbg_state
);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e AFTER_PAYLOAD = ST_CSUM;
`else
  localparam loader_state_e AFTER_PAYLOAD = ST_RUN;
`endif

  loader_state_e     state_q;
  logic [15:0]       len_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [XLEN-1:0]   imem_wdata_q;
  logic              core_rst_n_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic            hs;
  logic            word_valid;
  logic [XLEN-1:0] word;
  logic [15:0]     len_full;
  logic [16:0]     next_cnt;
  logic            last_word;
  logic            len_overflow;

  // A byte moves when rx_valid & rx_ready are both high at a rising edge;
  // rx_ready depends only on the current state, never on rx_valid.
  assign rx_ready = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                    (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign hs       = rx_valid && rx_ready;

  assign len_full     = {rx_data, len_q[7:0]};
  assign len_overflow = {16'd0, len_full} > 32'(IMEM_DEPTH);
  assign next_cnt     = 17'(word_cnt_q) + 17'd1;
  assign last_word    = next_cnt == {1'b0, len_q};

  byte_packer u_packer (
    .clk        (clk),
    .areset     (areset),
    .clr        (state_q != ST_DATA),
    .byte_valid (hs && (state_q == ST_DATA)),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q      <= ST_LEN0;
      len_q        <= 16'd0;
      word_cnt_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      imem_we_q    <= 1'b0;
      // Released one cycle after RUN is entered, so the last write always lands first.
      core_rst_n_q <= (state_q == ST_RUN) && !reload;
      case (state_q)
        ST_LEN0: begin
          if (hs) begin
            len_q[7:0] <= rx_data;
            state_q    <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (hs) begin
            len_q[15:8] <= rx_data;
            if (len_overflow)        state_q <= ST_ERR;
            else if (len_full == 0)  state_q <= AFTER_PAYLOAD;
            else                     state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
          if (hs) csum_q <= csum_q ^ rx_data;
`endif
          if (word_valid) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
            imem_wdata_q <= word;
            word_cnt_q   <= word_cnt_q + 1'b1;
            if (last_word) state_q <= AFTER_PAYLOAD;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (hs) state_q <= (rx_data == csum_q) ? ST_RUN : ST_ERR;
        end
`endif
        ST_RUN, ST_ERR: begin
          if (reload) begin
            state_q    <= ST_LEN0;
            len_q      <= 16'd0;
            word_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
          end
        end
        default: state_q <= ST_LEN0;
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = rx_ready;
  assign done       = state_q == ST_RUN;
  assign err        = state_q == ST_ERR;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader; follows LOADER_CHECKSUM_EN if defined.
module tb_program_loader;
  import loader_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          reload = 1'b0;
  logic          rx_ready, imem_we, core_rst_n, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  loader_state_e dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] mon_e;
  logic [31:0]    pay[0:DEPTH-1];

  program_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .areset     (areset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---- clock / watchdog ----
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---- monitor: every write strobe is matched against the expected queue ----
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                 imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(mon_e[AW+31:32]));
        chk("write_data", imem_wdata, mon_e[31:0]);
      end
    end
  end

  // ---- driver tasks (entered and left at posedge + 1) ----
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    bit taken;
    for (int g = 0; g < 8 && $urandom_range(0, 99) < gap_pct; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    taken    = 1'b0;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      taken = rx_ready;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!taken) begin
      n_checks++;
      $display("FAIL handshake_timeout: got rx_ready=0 for 50 cycles expected 1");
    end
  endtask

  task automatic finish_check(input bit expect_err, input int exp_writes);
    bit seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
    end
    chk("status_reached", 32'(seen), 32'd1);
    if (seen) begin
      if (expect_err) begin
        chk("err_set", 32'(err), 32'd1);
        chk("done_clear", 32'(done), 32'd0);
        chk("rx_ready_in_err", 32'(rx_ready), 32'd0);
        chk("core_rst_in_err", 32'(core_rst_n), 32'd0);
        @(negedge clk);
        chk("err_holds", 32'(err), 32'd1);
        chk("core_rst_err_hold", 32'(core_rst_n), 32'd0);
      end else begin
        chk("done_set", 32'(done), 32'd1);
        chk("err_clear", 32'(err), 32'd0);
        chk("core_rst_first_run_cycle", 32'(core_rst_n), 32'd0);
        @(negedge clk);
        chk("core_rst_rise", 32'(core_rst_n), 32'd1);
        chk("rx_ready_in_run", 32'(rx_ready), 32'd0);
        chk("busy_in_run", 32'(busy), 32'd0);
      end
    end
    #1;
    chk("write_count", 32'(wr_cnt), 32'(exp_writes));
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Reference: stream bytes, writes and outcome derived directly from the stream format.
  task automatic do_load(input int n, input bit bad_csum, input int gap_pct);
    logic [7:0] b;
    logic [7:0] cs;
    bit         expect_err;
    int         exp_writes;
    logic [15:0] n16;
    cs = 8'd0;
    wr_cnt = 0;
    n16 = 16'(n);
    send_byte(n16[7:0], gap_pct);
    send_byte(n16[15:8], gap_pct);
    if (n > DEPTH) begin
      expect_err = 1'b1;
      exp_writes = 0;
    end else begin
      for (int w = 0; w < n; w++) begin
        for (int k = 0; k < 4; k++) begin
          b  = pay[w][8*k +: 8];
          cs = cs ^ b;
          if (k == 3) exp_q.push_back({AW'(w), pay[w]});
          send_byte(b, gap_pct);
        end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(bad_csum ? (cs ^ 8'h01) : cs, gap_pct);
      expect_err = bad_csum;
`else
      expect_err = 1'b0;
`endif
      exp_writes = n;
    end
    finish_check(expect_err, exp_writes);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    @(negedge clk);
    chk("reload_core_rst", 32'(core_rst_n), 32'd0);
    chk("reload_rx_ready", 32'(rx_ready), 32'd1);
    chk("reload_busy", 32'(busy), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_err", 32'(err), 32'd0);
    @(posedge clk); #1;
  endtask

  // Reset mid-payload, with a byte offered in the reset cycle.
  task automatic do_abort(input int n, input int nbytes);
    logic [15:0] n16;
    wr_cnt = 0;
    n16 = 16'(n);
    send_byte(n16[7:0], 0);
    send_byte(n16[15:8], 0);
    for (int i = 0; i < nbytes; i++) begin
      if (i % 4 == 3) exp_q.push_back({AW'(i / 4), pay[i / 4]});
      send_byte(pay[i / 4][8*(i % 4) +: 8], 0);
    end
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    areset   = 1'b1;
    @(posedge clk); #1;
    areset   = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("abort_state_len0", 32'(dbg_state), 32'(ST_LEN0));
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_rx_ready", 32'(rx_ready), 32'd1);
    chk("abort_core_rst", 32'(core_rst_n), 32'd0);
    chk("abort_imem_addr", 32'(imem_addr), 32'd0);
    #1;
    chk("abort_write_count", 32'(wr_cnt), 32'(nbytes / 4));
    chk("abort_exp_q_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic fill_random(input int n);
    for (int w = 0; w < n; w++) pay[w] = $urandom;
  endtask

  // ---- main sequence ----
  initial begin
    repeat (3) @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;

    pay[0] = 32'h0000_0013;
    pay[1] = 32'h0010_0093;
    do_load(2, 1'b0, 0);
    do_reload();
`ifdef LOADER_CHECKSUM_EN
    do_load(2, 1'b1, 0);
    do_reload();
`endif

    do_load(DEPTH + 1, 1'b0, 0);
    do_reload();

    do_load(0, 1'b0, 0);
    do_reload();

    fill_random(4);
    do_load(4, 1'b0, 40);
    do_reload();

    fill_random(3);
    do_abort(3, 6);
    fill_random(2);
    do_load(2, 1'b0, 0);
    do_reload();

    fill_random(DEPTH);
    do_load(DEPTH, 1'b0, 0);
    do_reload();

    repeat (6) begin
      int n;
      n = $urandom_range(1, 12);
      fill_random(n);
      do_load(n, $urandom_range(0, 3) == 0, $urandom_range(0, 50));
      do_reload();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Stream-to-memory writer that fills the RV32 core's instruction memory from a byte stream, then releases the core from reset. It sits between an external byte source (bench driver or UART receiver) and the instruction-memory write port. It owns the core's reset line, so a freshly loaded program always starts from address 0. It is the writing counterpart to the bench's result readout from data memory.

## Interface
- `IMEM_DEPTH`, default 256: instruction memory depth in 32-bit words; power of two.
- `ADDR_W`, default 8: word-address width; must equal log2(`IMEM_DEPTH`).

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `areset`  in  1: synchronous, active-high reset.
- `rx_valid`  in  1: a byte is offered on `rx_data`.
- `rx_data`  in  8: stream byte.
- `rx_ready`  out  1: the loader accepts a byte this cycle.
- `reload`  in  1: single-cycle request to re-enter loading from RUN.
- `imem_we`  out  1: instruction-memory write strobe, one cycle wide.
- `imem_addr`  out  ADDR_W: word address for the write.
- `imem_wdata`  out  32: word to write.
- `core_rst_n`  out  1: core reset, active-low; 0 holds the core in reset.
- `busy`  out  1: loading is in progress.
- `done`  out  1: the load completed and the core is running.
- `err`  out  1: the load was aborted; the core stays in reset.

## Operation
- Stream format: `LEN_LO`, `LEN_HI` (16-bit word count N, little-endian), then N×4 payload bytes (each word little-endian), then one checksum byte when the checksum option is compiled in.
- Handshake: a byte transfers on any cycle with `rx_valid & rx_ready`. `rx_data` is ignored otherwise.
- FSM states:
  - LEN0: receives `LEN_LO`.
  - LEN1: receives `LEN_HI`.
  - DATA: receives payload bytes.
  - CSUM: receives the checksum byte (checksum build only).
  - RUN: load finished, core running.
  - ERR: load aborted.
- `rx_ready` is 1 in LEN0, LEN1, DATA and CSUM; it is 0 in RUN and ERR.
- Transitions:
  - LEN0 → LEN1 on handshake.
  - LEN1 → ERR if N > `IMEM_DEPTH`.
  - LEN1 → CSUM when N == 0 (checksum build); LEN1 → RUN when N == 0 (no-checksum build).
  - LEN1 → DATA otherwise.
  - DATA → CSUM (or RUN, no-checksum build) on the handshake of the last payload byte.
  - CSUM → RUN on a checksum match; CSUM → ERR on a mismatch.
  - RUN → LEN0 when `reload` is 1.
  - ERR → LEN0 when `reload` is 1.
  - `reload` is ignored in every other state.
- Word assembly: byte k (0..3) of a word goes to bits [8k+7:8k]. The word address starts at 0 and increments after each write. Writes never wrap, because N ≤ `IMEM_DEPTH` is checked in LEN1.
- Byte and word counters reset on entry to LEN0.
- Status outputs: `busy` = state ∈ {LEN0, LEN1, DATA, CSUM}; `done` = state == RUN; `err` = state == ERR.
- `core_rst_n` = 1 only in RUN.
- Reset: any state → LEN0. All outputs then take these values:
  - `core_rst_n` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0
  - `busy` = 1, `done` = 0, `err` = 0, `rx_ready` = 1
  - A partial word is discarded. Memory contents are left untouched.

## Timing
- `imem_we`, `imem_addr` and `imem_wdata` are registered. The strobe is asserted in the cycle after the handshake of the word's fourth byte and lasts exactly one cycle.
- Back-to-back bytes at one per cycle are supported with no stall.
- `core_rst_n` rises in the cycle after the FSM enters RUN. This is always at least one cycle after the final `imem_we`, so the core never fetches a word that has not been written.
- `reload` in RUN: `core_rst_n` falls in the next cycle and `rx_ready` is 1 in the same cycle.
- `areset` coinciding with a handshake: reset wins and the byte is dropped.

## Configuration
- `LOADER_CHECKSUM_EN`:
  - Defined: the CSUM state exists. The XOR of all payload bytes (0x00 when N == 0) must equal the received checksum byte, otherwise the FSM goes to ERR.
  - Undefined: no CSUM state and no checksum byte in the stream. ERR is reachable only through length overflow.

## Structure
- Shared package `loader_pkg` holds:
  - the FSM state encoding (LEN0=0, LEN1=1, DATA=2, CSUM=3, RUN=4, ERR=5)
  - `XLEN` = 32
  - `WORD_BYTES` = 4
- One sub-module, `byte_packer`: 2-bit lane counter plus a 32-bit shift register. It emits `word_valid`/`word` when the fourth byte is taken and has a sync clear.

## Test plan
- Load N=2, payload 13 00 00 00 93 00 10 00, checksum 0x90 (checksum build) → writes 0x00000013 to address 0 and 0x00100093 to address 1, `done`=1, `core_rst_n` rises one cycle after RUN.
- Same stream with checksum 0x91 → no `core_rst_n` rise, `err`=1, `rx_ready`=0; then `reload` → back in LEN0 with `busy`=1.
- N=257 with `IMEM_DEPTH`=256 → ERR after `LEN_HI`, zero writes.
- N=0 → `done` with no `imem_we` pulse (checksum build expects and checks 0x00).
- `rx_valid` toggled randomly with gaps during a 4-word load → addresses 0..3 in order, exactly 4 `imem_we` pulses.
- `areset` after 6 payload bytes, then a full load → the first write goes to address 0 and no stale bytes leak into word 0.
